// File: rtl/gcd_job_sequencer_pkg.sv
// Shared types for the GCD job sequencer: default data width and sequencer FSM states.
package gcd_pkg;
  localparam int GCD_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_CLR,
    WAIT_DONE,
    OUTPUT
  } seq_state_t;
endpackage

// File: rtl/gcd_job_sequencer_if.sv
// Operand input, result output and core-side signals of the GCD job sequencer.
interface gcd_job_sequencer_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_a;
  logic [WIDTH-1:0] gcd_b;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic             busy;

  // master: the environment (operand source, core, result sink)
  modport master (
    output in_valid, in_a, in_b, gcd_done, gcd_result, res_ready,
    input  in_ready, gcd_start, gcd_a, gcd_b, res_valid, res_data, res_err, busy
  );

  // slave: the sequencer itself
  modport slave (
    input  in_valid, in_a, in_b, gcd_done, gcd_result, res_ready,
    output in_ready, gcd_start, gcd_a, gcd_b, res_valid, res_data, res_err, busy
  );
endinterface

// File: rtl/gcd_job_sequencer_op_fifo.sv
// Operand-pair FIFO: DEPTH entries of W bits, extra pointer bit separates full from empty.
module gcd_op_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/gcd_job_sequencer.sv
// Wraps a subtractive GCD core: queues operand pairs, launches one job at a time,
// short-circuits zero operands and aborts jobs whose done never arrives.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH       = GCD_WIDTH,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  gcd_job_sequencer_if.slave    io
);
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] TMO_ONE  = 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_err_q, res_err_d;
  logic [CW-1:0]    tmo_q, tmo_d;

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [2*WIDTH-1:0] fifo_rdata;
  logic [WIDTH-1:0]   pop_a, pop_b;
  logic               pop_zero, tmo_hit;

  assign fifo_pop = (state_q == IDLE) && !fifo_empty;
  assign pop_a    = fifo_rdata[2*WIDTH-1:WIDTH];
  assign pop_b    = fifo_rdata[WIDTH-1:0];
  assign pop_zero = (pop_a == '0) || (pop_b == '0);
  assign tmo_hit  = (tmo_q == TMO_LAST);

  gcd_op_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (io.in_valid && !fifo_full),
    .wdata   ({io.in_a, io.in_b}),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      tmo_q      <= tmo_d;
    end
  end

  // Done wins over the timeout when both land on the last allowed cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!fifo_empty) state_d = pop_zero ? OUTPUT : LAUNCH;
      LAUNCH:    state_d = WAIT_CLR;
      WAIT_CLR: begin
        if (!io.gcd_done)  state_d = WAIT_DONE;
        else if (tmo_hit)  state_d = OUTPUT;
      end
      WAIT_DONE: if (io.gcd_done || tmo_hit) state_d = OUTPUT;
      OUTPUT:    if (io.res_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    tmo_d      = tmo_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          op_a_d = pop_a;
          op_b_d = pop_b;
          if (pop_zero) begin
            res_data_d = pop_a | pop_b;
            res_err_d  = 1'b0;
          end
        end
      end
      LAUNCH: tmo_d = '0;
      WAIT_CLR: begin
        tmo_d = tmo_q + TMO_ONE;
        if (io.gcd_done && tmo_hit) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
        end
      end
      WAIT_DONE: begin
        tmo_d = tmo_q + TMO_ONE;
        if (io.gcd_done) begin
          res_data_d = io.gcd_result;
          res_err_d  = 1'b0;
        end else if (tmo_hit) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    io.in_ready  = !fifo_full;
    io.gcd_start = (state_q == LAUNCH);
    io.gcd_a     = op_a_q;
    io.gcd_b     = op_b_q;
    io.res_valid = (state_q == OUTPUT);
    io.res_data  = res_data_q;
    io.res_err   = res_err_q;
    io.busy      = (state_q != IDLE) || !fifo_empty;
  end
endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Scoreboard bench for gcd_job_sequencer driving a behavioural subtractive GCD core;
// expected results come from a Euclid reference model pushed at operand acceptance.
module tb_gcd_job_sequencer;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  gcd_job_sequencer_if #(.WIDTH(8)) bus ();

  gcd_job_sequencer #(.WIDTH(8), .DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int rr_mode = 0;
  logic hang = 1'b0;
  logic [8:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: latches operands on start, subtracts one step per cycle,
  // done stays high until the next start. In hang mode it never finishes.
  logic       core_run;
  logic [7:0] ca, cb;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_run <= 1'b0; ca <= '0; cb <= '0;
      bus.gcd_done <= 1'b0; bus.gcd_result <= '0;
    end else if (bus.gcd_start) begin
      ca <= bus.gcd_a; cb <= bus.gcd_b; core_run <= 1'b1; bus.gcd_done <= 1'b0;
    end else if (core_run && !hang) begin
      if (ca == cb) begin
        bus.gcd_done <= 1'b1; bus.gcd_result <= ca; core_run <= 1'b0;
      end else if (ca > cb) ca <= ca - cb;
      else cb <= cb - ca;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       bus.res_ready = 1'b1;
      1:       bus.res_ready = 1'b0;
      default: bus.res_ready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic logic [8:0] ref_model(input logic [7:0] a, input logic [7:0] b, input logic h);
    int x, y, t;
    if (a == 0 || b == 0) return {1'b0, a | b};
    if (h) return {1'b1, 8'd0};
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return {1'b0, 8'(x)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Acceptance side of the scoreboard
  always @(negedge clk)
    if (reset_n && bus.in_valid && bus.in_ready)
      exp_q.push_back(ref_model(bus.in_a, bus.in_b, hang));

  // Result side of the scoreboard
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset_n && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got data %0d err %0d with nothing outstanding", bus.res_data, bus.res_err);
      end else begin
        e = exp_q.pop_front();
        chk("result", int'({bus.res_err, bus.res_data}), int'(e));
      end
    end
  end

  always @(negedge clk) if (reset_n && bus.gcd_start) start_cnt++;

  // Core operands must hold from launch until the result is presented.
  logic       armed = 1'b0;
  logic [7:0] la, lb;
  always @(negedge clk) begin
    if (!reset_n) armed = 1'b0;
    else if (bus.gcd_start) begin
      armed = 1'b1; la = bus.gcd_a; lb = bus.gcd_b;
    end else if (armed) begin
      chk("op_a_stable", int'(bus.gcd_a), int'(la));
      chk("op_b_stable", int'(bus.gcd_b), int'(lb));
      if (bus.res_valid) armed = 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n) bus.gcd_start |=> !bus.gcd_start)
    else $error("FAIL start_pulse: gcd_start high two cycles in a row");

  task automatic check_rst(input string tag);
    chk({tag, "_in_ready"},  int'(bus.in_ready),  1);
    chk({tag, "_gcd_start"}, int'(bus.gcd_start), 0);
    chk({tag, "_gcd_a"},     int'(bus.gcd_a),     0);
    chk({tag, "_gcd_b"},     int'(bus.gcd_b),     0);
    chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
    chk({tag, "_res_data"},  int'(bus.res_data),  0);
    chk({tag, "_res_err"},   int'(bus.res_err),   0);
    chk({tag, "_busy"},      int'(bus.busy),      0);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [7:0] a, input logic [7:0] b, output int acc);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    @(negedge clk);
    while (!bus.in_ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("push_timeout", 0, 1);
    acc = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.busy) && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_neg(input int which, input string name);
    int n = 0;
    @(negedge clk);
    while (!(which == 0 ? bus.gcd_start : bus.res_valid) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk(name, 0, 1);
  endtask

  initial begin
    int acc, s0, t0;
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rst("reset");
    @(posedge clk); #1 reset_n = 1'b1;

    // Basic launch
    s0 = start_cnt;
    push(8'd12, 8'd18, acc);
    wait_drain();
    chk("t1_start_count", start_cnt - s0, 1);

    // Zero operands bypass the core; result two cycles after acceptance
    s0 = start_cnt;
    push(8'd0, 8'd9, acc);
    wait_neg(1, "t2_valid_timeout");
    chk("t2_zero_latency", cyc - acc, 2);
    @(posedge clk); #1;
    push(8'd0, 8'd0, acc);
    push(8'd7, 8'd0, acc);
    wait_drain();
    chk("t2_start_count", start_cnt - s0, 0);

    // Minimum core latency: done one cycle after the clear phase
    push(8'd1, 8'd1, acc);
    wait_neg(1, "t1b_valid_timeout");
    chk("min_latency", cyc - acc, 5);
    wait_drain();

    // Back-pressure fills the FIFO
    rr_mode = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) push(8'($urandom_range(1, 15)), 8'($urandom_range(1, 15)), acc);
    @(negedge clk);
    chk("t3_in_ready_full", int'(bus.in_ready), 0);
    chk("t3_busy", int'(bus.busy), 1);
    @(posedge clk); #1;
    rr_mode = 0;
    wait_drain();

    // Timeout: decided 16 cycles after the start pulse, visible the cycle after
    hang = 1'b1;
    push(8'd3, 8'd5, acc);
    wait_neg(0, "t4_start_timeout");
    t0 = cyc;
    wait_neg(1, "t4_valid_timeout");
    chk("t4_timeout_latency", cyc - t0, 17);
    chk("t4_res_err", int'(bus.res_err), 1);
    chk("t4_res_data", int'(bus.res_data), 0);
    @(posedge clk); #1;
    hang = 1'b0;
    wait_drain();

    // Reset during WAIT_DONE abandons the job
    push(8'd15, 8'd10, acc);
    wait_neg(0, "t5_start_timeout");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_rst("t5_midreset");
    exp_q.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    push(8'd4, 8'd6, acc);
    wait_drain();

    // Sweep with random back-pressure and random gaps
    rr_mode = 2;
    for (int a = 1; a <= 15; a++)
      for (int b = 1; b <= 15; b++) begin
        push(8'(a), 8'(b), acc);
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
    for (int i = 0; i < 40; i++) push(8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), acc);
    wait_drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
